// File: rtl/combi_pkg.sv
// Shared types and signature constants for the data-memory checker.
package combi_pkg;

    typedef enum logic [2:0] {
        StRun,
        StPassDrain,
        StPass,
        StFail,
        StTmo
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsArm,
        ClsRv,
        ClsScratch,
        ClsIllegal
    } store_cls_e;

    localparam logic [31:0] ARM_SIG_ADR = 32'd100;
    localparam logic [31:0] ARM_SIG_DAT = 32'd7;
    localparam logic [31:0] RV_SIG_ADR  = 32'd192;
    localparam logic [31:0] RV_SIG_DAT  = 32'd25;
    localparam logic [31:0] SCRATCH_ADR = 32'd96;

    // A store that misses the memory or is misaligned is illegal whatever its address.
    function automatic store_cls_e classify(logic we, logic adr_ok, logic [31:0] adr,
                                            logic [31:0] dat);
        if (!we) return ClsNone;
        if (!adr_ok) return ClsIllegal;
        if (adr == ARM_SIG_ADR && dat == ARM_SIG_DAT) return ClsArm;
        if (adr == RV_SIG_ADR && dat == RV_SIG_DAT) return ClsRv;
        if (adr == SCRATCH_ADR) return ClsScratch;
        return ClsIllegal;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data memory: synchronous write, combinational read, no reset.
module dmem_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_check.sv
// Data memory plus store classifier that turns signature stores into a pass/fail/timeout verdict.
module dmem_check
    import combi_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned TIMEOUT_CYC = 100,
    parameter int unsigned DRAIN_CYC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ArmOk,
    output logic        Pass,
    output logic        Fail,
    output logic        Timeout,
    output logic        Done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] TMO_MAX    = CW'(TIMEOUT_CYC);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);

    logic          in_range;
    logic          aligned;
    logic [31:0]   ram_rdata;
    store_cls_e    cls;
    state_e        state_q;
    logic [CW-1:0] tmo_cnt_q;
    logic [DW-1:0] drain_q;

    assign in_range = DataAdr < 32'(4 * DEPTH);
    assign aligned  = DataAdr[1:0] == 2'b00;
    assign cls      = classify(MemWrite, in_range && aligned, DataAdr, WriteData);
    assign ReadData = in_range ? ram_rdata : 32'd0;

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (MemWrite && in_range && aligned),
        .addr  (DataAdr[AW+1:2]),
        .wdata (WriteData),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            tmo_cnt_q <= '0;
            drain_q   <= '0;
            ArmOk     <= 1'b0;
            Pass      <= 1'b0;
            Fail      <= 1'b0;
            Timeout   <= 1'b0;
            Done      <= 1'b0;
        end else begin
            if (cls == ClsArm) ArmOk <= 1'b1;
            case (state_q)
                StRun: begin
                    if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    // A verdict-forming store beats a timeout expiring in the same cycle.
                    if (cls == ClsRv) begin
                        state_q <= StPassDrain;
                        drain_q <= DRAIN_INIT;
                        Pass    <= 1'b1;
                    end else if (cls == ClsIllegal) begin
                        state_q <= StFail;
                        Fail    <= 1'b1;
                        Done    <= 1'b1;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        state_q <= StTmo;
                        Timeout <= 1'b1;
                        Done    <= 1'b1;
                    end
                end
                StPassDrain: begin
                    if (drain_q == '0) begin
                        state_q <= StPass;
                        Done    <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_check.sv
// Table-driven bench for dmem_check with an expected-result queue per applied vector.
module tb_dmem_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        ArmOk, Pass, Fail, Timeout, Done;
    logic [4:0]  flags;

    always #5 clk = ~clk;

    assign flags = {ArmOk, Pass, Fail, Timeout, Done};

    dmem_check #(
        .DEPTH       (64),
        .TIMEOUT_CYC (100),
        .DRAIN_CYC   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .ArmOk     (ArmOk),
        .Pass      (Pass),
        .Fail      (Fail),
        .Timeout   (Timeout),
        .Done      (Done)
    );

    typedef struct {
        bit          rst;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [4:0]  fl;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [4:0]  fl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [31:0] rd_e, input logic [4:0] fl_e);
        nvec++;
        if (ReadData !== rd_e || flags !== fl_e) begin
            nerr++;
            $display("FAIL %s: ReadData=%h flags(AkPsFlToDn)=%b, want ReadData=%h flags=%b",
                     name, ReadData, flags, rd_e, fl_e);
        end
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive at a negedge, push the expectation, compare just after the next rising edge.
    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [4:0] fl, input string name);
        exp_t e;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        sb.push_back('{name: name, rd: rd, fl: fl});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.rd, e.fl);
        @(negedge clk);
    endtask

    task automatic add(input bit rst, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [4:0] fl,
                       input string name);
        vecs.push_back('{rst: rst, we: we, adr: adr, wd: wd, rd: rd, fl: fl, name: name});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // flags order: ArmOk Pass Fail Timeout Done
        add(1, 1, 96,  32'hDEAD, 32'hDEAD, 5'b00000, "scratch_store");
        add(0, 0, 96,  0,        32'hDEAD, 5'b00000, "scratch_load");
        add(0, 0, 97,  0,        32'hDEAD, 5'b00000, "load_lowbits_ignored");
        add(0, 1, 100, 7,        7,        5'b10000, "arm_sig");
        add(0, 1, 192, 25,       25,       5'b11000, "rv_sig_pass");
        add(0, 0, 96,  0,        32'hDEAD, 5'b11000, "drain_1");
        add(0, 1, 104, 3,        3,        5'b11000, "drain_illegal_keeps_pass");
        add(0, 0, 100, 0,        7,        5'b11000, "drain_3");
        add(0, 0, 104, 0,        3,        5'b11001, "done_after_4");
        add(0, 1, 192, 25,       25,       5'b11001, "pass_terminal");
        add(0, 0, 256, 0,        0,        5'b11001, "load_out_of_range");
        add(1, 1, 104, 3,        3,        5'b00101, "illegal_fail");
        add(0, 1, 192, 25,       25,       5'b00101, "fail_blocks_pass");
        add(0, 1, 100, 7,        7,        5'b10101, "arm_in_fail");
        add(0, 1, 0,   32'h11,   32'h11,   5'b10101, "write_in_fail");
        add(1, 1, 256, 1,        0,        5'b00101, "oor_store_fail");
        add(0, 0, 0,   0,        32'h11,   5'b00101, "oor_store_no_alias");
        add(0, 1, 98,  5,        32'hDEAD, 5'b00101, "misaligned_no_write");
        add(0, 0, 99,  0,        32'hDEAD, 5'b00101, "misaligned_reload");

        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd256;
        WriteData = 32'd0;
        #1;
        check("reset_state", 32'd0, 5'b00000);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].fl, vecs[i].name);
        end

        // Timeout on the 100th cycle with no stores.
        do_reset();
        for (int i = 0; i < 99; i++) step(0, 96, 0, 32'hDEAD, 5'b00000, "tmo_idle");
        step(0, 96, 0, 32'hDEAD, 5'b00011, "tmo_expire");
        step(1, 192, 25, 25, 5'b00011, "tmo_blocks_pass");

        // Signature store on the expiry cycle wins, then reset mid-drain.
        do_reset();
        for (int i = 0; i < 99; i++) step(0, 96, 0, 32'hDEAD, 5'b00000, "race_idle");
        step(1, 192, 25, 25, 5'b01000, "race_rv_wins");
        step(0, 192, 0, 25, 5'b01000, "race_draining");
        reset   = 1'b1;
        DataAdr = 32'd96;
        #1;
        check("reset_mid_drain", 32'hDEAD, 5'b00000);
        DataAdr = 32'd192;
        #1;
        check("reset_keeps_mem", 32'd25, 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 100, 0, 7, 5'b00000, "restart_run");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
